// File: rtl/ra_pkg.sv
// ra_pkg: shared widths, state type and spare structure codes for the redundancy-analysis datapath
package ra_pkg;
  localparam int DSSS_W = 8;
  localparam int DSSS_K = 4;
  localparam int RLSS_W = 4;
  localparam int RLSS_K = 2;
  typedef enum logic {IDLE, RUN} state_e;
  localparam logic [1:0] STRUCT1 = 2'd1;
  localparam logic [1:0] STRUCT2 = 2'd2;
  localparam logic [1:0] STRUCT3 = 2'd3;
endpackage

// File: rtl/next_combination.sv
// next_combination: next larger value with the same popcount, plus a flag when x is the top pattern
module next_combination #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] nxt,
  output logic         last
);
  localparam int P_W = $clog2(W);
  logic [W:0] sum;
  logic [W-1:0] low, ones;
  logic [P_W-1:0] p;
  // Adding the lowest set bit ripples the lowest run of ones into bit q; the run's
  // surplus ones are then re-packed at the bottom with a shift instead of a divide.
  always_comb begin
    low = x & (~x + W'(1));
    sum = {1'b0, x} + {1'b0, low};
    ones = x ^ sum[W-1:0];
    p = '0;
    for (int i = W - 1; i >= 0; i--) p = low[i] ? P_W'(i) : p;
    nxt = sum[W-1:0] | ((ones >> 2) >> p);
    last = sum[W];
  end
endmodule

// File: rtl/spare_signal_generator.sv
// spare_signal_generator: enumerates every DSSS/RLSS candidate pair over a valid/ready handshake
module spare_signal_generator #(
  parameter int DSSS_W = ra_pkg::DSSS_W,
  parameter int DSSS_K = ra_pkg::DSSS_K,
  parameter int RLSS_W = ra_pkg::RLSS_W,
  parameter int RLSS_K = ra_pkg::RLSS_K,
  parameter int IDX_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        struct_sel,
  input  logic              stop,
  input  logic              cand_ready,
  output logic              cand_valid,
  output logic [DSSS_W-1:0] cand_dsss,
  output logic [RLSS_W-1:0] cand_rlss,
  output logic [1:0]        cand_struct,
  output logic [IDX_W-1:0]  cand_idx,
  output logic              busy,
  output logic              done,
  output logic              exhausted
);
  import ra_pkg::*;
  localparam logic [DSSS_W-1:0] DSSS_LO = DSSS_W'((1 << DSSS_K) - 1);
  localparam logic [RLSS_W-1:0] RLSS_LO = RLSS_W'((1 << RLSS_K) - 1);
  state_e state_q, state_d;
  logic valid_q, valid_d, done_q, done_d, exh_q, exh_d;
  logic [DSSS_W-1:0] dsss_q, dsss_d, dsss_nxt;
  logic [RLSS_W-1:0] rlss_q, rlss_d, rlss_nxt;
  logic [1:0] struct_q, struct_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic dsss_last, rlss_last, launch, fin, adv;
  next_combination #(.W(DSSS_W)) u_dsss (.x(dsss_q), .nxt(dsss_nxt), .last(dsss_last));
  next_combination #(.W(RLSS_W)) u_rlss (.x(rlss_q), .nxt(rlss_nxt), .last(rlss_last));
  assign launch = (state_q == IDLE) & start;
  // stop overrides a same-cycle handshake, so fin never advances the candidate
  assign fin = (state_q == RUN) & (stop | (valid_q & cand_ready & dsss_last & rlss_last));
  assign adv = (state_q == RUN) & valid_q & cand_ready & ~fin;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      exh_q    <= 1'b0;
      dsss_q   <= '0;
      rlss_q   <= '0;
      struct_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      exh_q    <= exh_d;
      dsss_q   <= dsss_d;
      rlss_q   <= rlss_d;
      struct_q <= struct_d;
      idx_q    <= idx_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (start ? RUN : IDLE) : (fin ? IDLE : RUN);
  end
  always_comb begin
    valid_d  = launch | (valid_q & ~fin);
    done_d   = fin;
    exh_d    = launch ? 1'b0 : fin ? ~stop : exh_q;
    dsss_d   = launch ? DSSS_LO : (adv & rlss_last) ? dsss_nxt : dsss_q;
    rlss_d   = launch ? RLSS_LO : adv ? (rlss_last ? RLSS_LO : rlss_nxt) : rlss_q;
    idx_d    = launch ? '0 : adv ? idx_q + IDX_W'(1) : idx_q;
    struct_d = launch ? struct_sel : struct_q;
  end
  assign cand_valid  = valid_q;
  assign cand_dsss   = dsss_q;
  assign cand_rlss   = rlss_q;
  assign cand_struct = struct_q;
  assign cand_idx    = idx_q;
  assign busy        = state_q == RUN;
  assign done        = done_q;
  assign exhausted   = exh_q;
endmodule
